// File: rtl/cmd_dispatch_pkg.sv
// Shared definitions for the command dispatcher: opcodes, header field
// positions, FSM state encodings and the payload-size helper.
package cmd_dispatch_pkg;

   localparam logic [7:0]  OP_NOP      = 8'h00;

   localparam int unsigned WORD_W      = 32;
   localparam int unsigned HDR_OPC_LSB = 0;
   localparam int unsigned HDR_TGT_LSB = 8;
   localparam int unsigned HDR_CNT_LSB = 16;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_FETCH  = 2'd1,
      ST_STREAM = 2'd2
   } state_t;

   // Payload words that fit behind the 32-bit header of a WIDTH-byte command.
   function automatic int unsigned max_words(input int unsigned width);
      return (8 * width - WORD_W) / WORD_W;
   endfunction

endpackage

// File: rtl/cmd_dispatch_word_sel.sv
// Payload word mux: picks 32-bit word 'idx' out of the command payload.
// Indices past the last payload word return zero.
module cmd_dispatch_word_sel
   import cmd_dispatch_pkg::*;
#(
   parameter  int unsigned WIDTH = 256,
   localparam int unsigned MAXW  = max_words(WIDTH),
   localparam int unsigned IDXW  = $clog2(MAXW + 1)
) (
   input  logic [8*WIDTH-WORD_W-1:0] payload,
   input  logic [IDXW-1:0]           idx,
   output logic [WORD_W-1:0]         word
);

   logic [IDXW+4:0] base;

   assign base = {idx, 5'b0};

   // Select the indexed word, guarding the out-of-range index.
   always_comb begin
      word = '0;
      if (32'(idx) < MAXW) begin
         word = payload[base +: WORD_W];
      end
   end

endmodule

// File: rtl/cmd_dispatch.sv
// Command dispatcher: pops fixed-size commands from the upstream FIFO,
// decodes the header and streams payload words over valid/ready.
// NOP and over-length commands are dropped here.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// ST_IDLE   | waiting for a command; pops as soon as the FIFO is non-empty
// ST_FETCH  | popped header visible on fifo_data; decide drop or stream
// ST_STREAM | presenting payload beats; pops the next command on last beat
module cmd_dispatch
   import cmd_dispatch_pkg::*;
#(
   parameter int unsigned WIDTH = 256
) (
   input  logic                 CLK,
   input  logic                 rst_n,
   input  logic                 fifo_empty,
   output logic                 fifo_rd_en,
   input  logic [8*WIDTH-1:0]   fifo_data,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [7:0]           out_opcode,
   output logic [7:0]           out_target,
   output logic [WORD_W-1:0]    out_data,
   output logic                 out_first,
   output logic                 out_last,
   output logic                 err_len,
   output logic [15:0]          cmd_count,
   output logic [7:0]           err_count,
   output logic                 busy
);

   localparam int unsigned MAXW = max_words(WIDTH);
   localparam int unsigned IDXW = $clog2(MAXW + 1);

   state_t            state;
   state_t            state_nxt;

   logic [IDXW-1:0]   idx;
   logic [IDXW-1:0]   idx_nxt;
   logic [IDXW-1:0]   idx_inc;
   logic [IDXW-1:0]   last_idx;
   logic [IDXW-1:0]   last_idx_nxt;
   logic [IDXW-1:0]   sel_idx;
   logic [WORD_W-1:0] sel_word;

   logic [7:0]        hdr_opc;
   logic [7:0]        hdr_tgt;
   logic [15:0]       hdr_cnt;
   logic              hdr_nop;
   logic              hdr_bad;

   logic              valid_nxt;
   logic              first_nxt;
   logic              last_nxt;
   logic [WORD_W-1:0] data_nxt;
   logic [7:0]        opc_nxt;
   logic [7:0]        tgt_nxt;
   logic              handshake;
   logic              cmd_inc;
   logic              err_inc;

   // The header is only meaningful in ST_FETCH; the FIFO holds it until the next pop.
   assign hdr_opc = fifo_data[HDR_OPC_LSB +: 8];
   assign hdr_tgt = fifo_data[HDR_TGT_LSB +: 8];
   assign hdr_cnt = fifo_data[HDR_CNT_LSB +: 16];
   assign hdr_nop = (hdr_opc == OP_NOP);
   assign hdr_bad = (32'(hdr_cnt) > MAXW);

   assign idx_inc   = idx + 1'b1;
   assign handshake = out_valid & out_ready;
   assign busy      = (state != ST_IDLE);

   // Registered out_data needs the word that will be shown next cycle:
   // word 0 when entering the stream, idx+1 while advancing.
   assign sel_idx = (state == ST_STREAM) ? idx_inc : '0;

   cmd_dispatch_word_sel #(
      .WIDTH   (WIDTH)
   ) u_word_sel (
      .payload (fifo_data[8*WIDTH-1:WORD_W]),
      .idx     (sel_idx),
      .word    (sel_word)
   );

   // State register.
   always_ff @(posedge CLK or negedge rst_n) begin
      if (!rst_n) begin
         state <= ST_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next-state, FIFO pop and next values of the registered beat outputs.
   always_comb begin
      state_nxt    = state;
      idx_nxt      = idx;
      last_idx_nxt = last_idx;
      valid_nxt    = out_valid;
      first_nxt    = out_first;
      last_nxt     = out_last;
      data_nxt     = out_data;
      opc_nxt      = out_opcode;
      tgt_nxt      = out_target;
      fifo_rd_en   = 1'b0;
      err_len      = 1'b0;
      cmd_inc      = 1'b0;
      err_inc      = 1'b0;

      case (state)
         ST_IDLE: begin
            if (!fifo_empty) begin
               fifo_rd_en = 1'b1;
               state_nxt  = ST_FETCH;
            end
         end

         ST_FETCH: begin
            idx_nxt      = '0;
            last_idx_nxt = hdr_cnt[IDXW-1:0] - 1'b1;
            opc_nxt      = hdr_opc;
            tgt_nxt      = hdr_tgt;
            if (hdr_nop) begin
               state_nxt = ST_IDLE;
            end else if (hdr_bad) begin
               err_len   = 1'b1;
               err_inc   = 1'b1;
               state_nxt = ST_IDLE;
            end else begin
               state_nxt = ST_STREAM;
               valid_nxt = 1'b1;
               first_nxt = 1'b1;
               // A zero-length command still produces a single empty beat.
               last_nxt  = (hdr_cnt <= 16'd1);
               data_nxt  = (hdr_cnt == 16'd0) ? '0 : sel_word;
            end
         end

         ST_STREAM: begin
            if (handshake) begin
               if (!out_last) begin
                  idx_nxt   = idx_inc;
                  first_nxt = 1'b0;
                  last_nxt  = (idx_inc == last_idx);
                  data_nxt  = sel_word;
               end else begin
                  cmd_inc   = 1'b1;
                  valid_nxt = 1'b0;
                  first_nxt = 1'b0;
                  last_nxt  = 1'b0;
                  if (!fifo_empty) begin
                     fifo_rd_en = 1'b1;
                     state_nxt  = ST_FETCH;
                  end else begin
                     state_nxt  = ST_IDLE;
                  end
               end
            end
         end

         default: begin
            state_nxt = ST_IDLE;
         end
      endcase
   end

   // Beat outputs, word index and the dispatch/error counters.
   always_ff @(posedge CLK or negedge rst_n) begin
      if (!rst_n) begin
         idx        <= '0;
         last_idx   <= '0;
         out_valid  <= 1'b0;
         out_first  <= 1'b0;
         out_last   <= 1'b0;
         out_data   <= '0;
         out_opcode <= '0;
         out_target <= '0;
         cmd_count  <= '0;
         err_count  <= '0;
      end else begin
         idx        <= idx_nxt;
         last_idx   <= last_idx_nxt;
         out_valid  <= valid_nxt;
         out_first  <= first_nxt;
         out_last   <= last_nxt;
         out_data   <= data_nxt;
         out_opcode <= opc_nxt;
         out_target <= tgt_nxt;
         if (cmd_inc) begin
            cmd_count <= cmd_count + 16'd1;
         end
         if (err_inc && (err_count != 8'hFF)) begin
            err_count <= err_count + 8'd1;
         end
      end
   end

endmodule

// File: tb/tb_cmd_dispatch.sv
// Bench for cmd_dispatch: behavioural FIFO upstream, directed commands,
// expected beats queued at issue time and checked by an independent monitor.
module tb_cmd_dispatch;

   localparam int W  = 256;
   localparam int DW = 8 * W;

   typedef struct packed {
      logic [7:0]  opc;
      logic [7:0]  tgt;
      logic [31:0] data;
      logic        first;
      logic        last;
   } beat_t;

   logic          CLK = 1'b0;
   logic          rst_n = 1'b0;
   logic          fifo_empty = 1'b1;
   logic          fifo_rd_en;
   logic [DW-1:0] fifo_data = '0;
   logic          out_valid;
   logic          out_ready = 1'b1;
   logic [7:0]    out_opcode;
   logic [7:0]    out_target;
   logic [31:0]   out_data;
   logic          out_first;
   logic          out_last;
   logic          err_len;
   logic [15:0]   cmd_count;
   logic [7:0]    err_count;
   logic          busy;

   int checks = 0;
   int errors = 0;
   int cyc    = 0;

   beat_t         exp_q[$];
   logic [DW-1:0] stage_q[$];
   logic [DW-1:0] fifo_q[$];

   logic [15:0] exp_cmd    = '0;
   logic [7:0]  exp_err    = '0;
   int          exp_pulses = 0;
   int          err_pulses = 0;
   int          gap_checks = 0;
   bit          bp_en      = 1'b0;

   cmd_dispatch #(.WIDTH(W)) dut (
      .CLK        (CLK),
      .rst_n      (rst_n),
      .fifo_empty (fifo_empty),
      .fifo_rd_en (fifo_rd_en),
      .fifo_data  (fifo_data),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_opcode (out_opcode),
      .out_target (out_target),
      .out_data   (out_data),
      .out_first  (out_first),
      .out_last   (out_last),
      .err_len    (err_len),
      .cmd_count  (cmd_count),
      .err_count  (err_count),
      .busy       (busy)
   );

   always #5 CLK = ~CLK;

   initial begin
      #2ms;
      $display("FAIL watchdog: simulation did not complete in time");
      $fatal(1);
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Upstream FIFO: data_out changes only on a pop, flushed with reset.
   always @(posedge CLK) begin
      cyc <= cyc + 1;
      if (!rst_n) begin
         fifo_q.delete();
         fifo_empty <= 1'b1;
      end else begin
         if (fifo_rd_en && fifo_q.size() > 0) fifo_data <= fifo_q.pop_front();
         while (stage_q.size() > 0) fifo_q.push_back(stage_q.pop_front());
         fifo_empty <= (fifo_q.size() == 0);
      end
   end

   // out_ready: held high, or the 1,0,0,1 backpressure pattern.
   initial begin
      int k;
      k = 0;
      forever begin
         @(posedge CLK);
         #1;
         if (bp_en) begin
            out_ready = ((k % 4) == 0) || ((k % 4) == 3);
            k++;
         end else begin
            out_ready = 1'b1;
         end
      end
   end

   // Monitor: compares each presented beat against the scoreboard head.
   initial begin
      bit    prev_stall;
      bit    prev_valid;
      bit    b2b_pend;
      int    b2b_cyc;
      int    last_pop_cyc;
      beat_t act;
      beat_t e;
      prev_stall   = 0;
      prev_valid   = 0;
      b2b_pend     = 0;
      b2b_cyc      = 0;
      last_pop_cyc = -100;
      forever begin
         @(negedge CLK);
         if (!rst_n) begin
            prev_stall = 0;
            prev_valid = 0;
            b2b_pend   = 0;
         end else begin
            if (fifo_rd_en && fifo_empty) chk("rd_en_while_empty", 32'(fifo_rd_en), 32'h0);
            if (err_len) err_pulses++;
            if (prev_stall) chk("valid_held_in_stall", 32'(out_valid), 32'h1);
            if (out_valid) begin
               if (out_first && !prev_valid) begin
                  chk("pop_to_first_beat", 32'(cyc - last_pop_cyc), 32'd2);
                  if (b2b_pend) begin
                     chk("b2b_gap", 32'(cyc - b2b_cyc), 32'd2);
                     gap_checks++;
                     b2b_pend = 0;
                  end
               end
               act = {out_opcode, out_target, out_data, out_first, out_last};
               checks++;
               if (exp_q.size() == 0) begin
                  errors++;
                  $display("FAIL beat_unexpected: got op=%h tgt=%h data=%h f=%b l=%b expected no beat",
                           act.opc, act.tgt, act.data, act.first, act.last);
               end else begin
                  e = exp_q[0];
                  if (act !== e) begin
                     errors++;
                     $display("FAIL beat: got op=%h tgt=%h data=%h f=%b l=%b expected op=%h tgt=%h data=%h f=%b l=%b",
                              act.opc, act.tgt, act.data, act.first, act.last,
                              e.opc, e.tgt, e.data, e.first, e.last);
                  end
                  if (out_ready) void'(exp_q.pop_front());
               end
               if (out_ready && out_last) begin
                  chk("rd_en_on_last_beat", 32'(fifo_rd_en), 32'(!fifo_empty));
                  if (fifo_rd_en) begin
                     b2b_pend = 1;
                     b2b_cyc  = cyc;
                  end
               end
            end
            if (fifo_rd_en) last_pop_cyc = cyc;
            prev_stall = out_valid && !out_ready;
            prev_valid = out_valid;
         end
      end
   end

   // Build a command (unused payload words filled with junk) and queue its expected effect.
   task automatic send_cmd(input logic [7:0] op, input logic [7:0] tgt,
                           input logic [15:0] n, input logic [31:0] base);
      logic [DW-1:0] c;
      c = '0;
      for (int i = 0; i < 63; i++) c[32 + 32*i +: 32] = 32'hDEAD_0000 | 32'(i);
      c[31:0] = {n, tgt, op};
      for (int i = 0; i < 63 && i < int'(n); i++) c[32 + 32*i +: 32] = base + 32'(i);
      stage_q.push_back(c);
      if (op == 8'h00) begin
         // dropped silently
      end else if (n > 16'd63) begin
         exp_pulses++;
         if (exp_err != 8'hFF) exp_err++;
      end else if (n == 16'd0) begin
         exp_q.push_back('{opc: op, tgt: tgt, data: 32'h0, first: 1'b1, last: 1'b1});
         exp_cmd++;
      end else begin
         for (int i = 0; i < int'(n); i++)
            exp_q.push_back('{opc: op, tgt: tgt, data: base + 32'(i),
                              first: (i == 0), last: (i == int'(n) - 1)});
         exp_cmd++;
      end
   endtask

   task automatic wait_idle(input string name);
      int k;
      k = 0;
      while (k < 2000) begin
         @(negedge CLK);
         if (stage_q.size() == 0 && fifo_empty && !busy && exp_q.size() == 0) break;
         k++;
      end
      if (k >= 2000) chk({name, "_timeout"}, 32'h1, 32'h0);
   endtask

   task automatic check_counts(input string name);
      chk({name, "_cmd_count"}, 32'(cmd_count), 32'(exp_cmd));
      chk({name, "_err_count"}, 32'(err_count), 32'(exp_err));
      chk({name, "_err_pulses"}, 32'(err_pulses), 32'(exp_pulses));
   endtask

   task automatic check_reset_vals(input string name);
      chk({name, "_out_valid"}, 32'(out_valid), 32'h0);
      chk({name, "_out_first"}, 32'(out_first), 32'h0);
      chk({name, "_out_last"}, 32'(out_last), 32'h0);
      chk({name, "_out_data"}, out_data, 32'h0);
      chk({name, "_out_opcode"}, 32'(out_opcode), 32'h0);
      chk({name, "_out_target"}, 32'(out_target), 32'h0);
      chk({name, "_cmd_count"}, 32'(cmd_count), 32'h0);
      chk({name, "_err_count"}, 32'(err_count), 32'h0);
      chk({name, "_busy"}, 32'(busy), 32'h0);
      chk({name, "_err_len"}, 32'(err_len), 32'h0);
   endtask

   initial begin
      int k;
      repeat (3) @(negedge CLK);
      check_reset_vals("reset");
      chk("reset_rd_en", 32'(fifo_rd_en), 32'h0);
      rst_n = 1'b1;
      repeat (2) @(negedge CLK);

      send_cmd(8'h12, 8'h03, 16'd4, 32'h0000_00A0);
      wait_idle("single");
      check_counts("single");

      bp_en = 1'b1;
      send_cmd(8'h12, 8'h03, 16'd4, 32'h0000_00A0);
      wait_idle("backpressure");
      bp_en = 1'b0;
      check_counts("backpressure");

      send_cmd(8'h40, 8'h01, 16'd2, 32'h0000_00B0);
      send_cmd(8'h41, 8'h02, 16'd2, 32'h0000_00C0);
      wait_idle("b2b");
      check_counts("b2b");
      chk("b2b_gap_seen", 32'(gap_checks), 32'd1);

      send_cmd(8'h21, 8'h05, 16'd0, 32'h0000_0000);
      wait_idle("len0");
      check_counts("len0");

      send_cmd(8'h33, 8'h07, 16'd63, 32'h1000_0000);
      wait_idle("len63");
      check_counts("len63");

      send_cmd(8'h55, 8'h09, 16'd64, 32'h2000_0000);
      wait_idle("len64");
      check_counts("len64");

      send_cmd(8'h00, 8'h04, 16'd4, 32'h3000_0000);
      wait_idle("nop");
      check_counts("nop");

      for (int i = 0; i < 256; i++) send_cmd(8'h66, 8'h01, 16'(64 + i), 32'h0);
      wait_idle("err_sat");
      check_counts("err_sat");

      @(negedge CLK);
      force dut.cmd_count = 16'hFFFF;
      @(negedge CLK);
      release dut.cmd_count;
      exp_cmd = 16'hFFFF;
      send_cmd(8'h77, 8'h02, 16'd1, 32'h0000_00E0);
      wait_idle("wrap");
      check_counts("wrap");

      send_cmd(8'h88, 8'h06, 16'd20, 32'h0000_0F00);
      k = 0;
      while (!out_valid && k < 50) begin
         @(negedge CLK);
         k++;
      end
      chk("rst_stream_started", 32'(out_valid), 32'h1);
      repeat (3) @(negedge CLK);
      #2;
      rst_n = 1'b0;
      #1;
      check_reset_vals("async_rst");
      exp_q.delete();
      exp_cmd = '0;
      exp_err = '0;
      repeat (3) @(negedge CLK);
      rst_n = 1'b1;
      repeat (10) @(negedge CLK);
      chk("post_rst_busy", 32'(busy), 32'h0);
      chk("post_rst_valid", 32'(out_valid), 32'h0);
      chk("post_rst_rd_en", 32'(fifo_rd_en), 32'h0);
      chk("post_rst_cmd_count", 32'(cmd_count), 32'h0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
